// File: rtl/sorted_mem_reader.sv
// sorted_mem_reader: scans the sorted RAM for order violations, then browses entries on HEX displays
module sorted_mem_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int N = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sort_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              step_n,
  output logic              verify_done,
  output logic              sorted_ok,
  output logic              err_flag,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5
);
  typedef enum logic [2:0] {IDLE, REQ, CHK, BROWSE_REQ, BROWSE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [6:0] BLANK = 7'h7F;
  state_t state;
  logic [DATA_W-1:0] prev, data_q;
  logic [ADDR_W-1:0] err_addr;
  logic step_q, fresh, show_err, viol, browsing;
  logic [7:0] addr_disp, data_disp;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction
  assign viol = (rd_addr != '0) && (rd_data < prev);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_addr     <= '0;
      rd_en       <= 1'b0;
      verify_done <= 1'b0;
      sorted_ok   <= 1'b0;
      err_flag    <= 1'b0;
      prev        <= '0;
      data_q      <= '0;
      err_addr    <= '0;
      step_q      <= 1'b1;
      fresh       <= 1'b0;
      show_err    <= 1'b0;
    end else begin
      step_q <= step_n;
      rd_en  <= 1'b0;
      fresh  <= 1'b0;
      case (state)
        IDLE: if (sort_done) begin
          rd_addr <= '0;
          rd_en   <= 1'b1;
          state   <= REQ;
        end
        REQ: state <= CHK;
        CHK: begin
          prev  <= rd_data;
          rd_en <= 1'b1;
          if (viol) begin
            err_flag <= 1'b1;
            if (!err_flag) err_addr <= rd_addr;
          end
          if (rd_addr == LAST) begin
            verify_done <= 1'b1;
            sorted_ok   <= ~(err_flag | viol);
            show_err    <= err_flag | viol;
            rd_addr     <= '0;
            state       <= BROWSE_REQ;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            state   <= REQ;
          end
        end
        BROWSE_REQ: begin
          fresh <= 1'b1;
          state <= BROWSE;
        end
        BROWSE: begin
          if (fresh) data_q <= rd_data;
          // a press is a 1->0 transition, so holding the button counts once
          if (step_q && !step_n) begin
            rd_addr  <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
            rd_en    <= 1'b1;
            show_err <= 1'b0;
            state    <= BROWSE_REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // fresh read data is shown the cycle it arrives, the latched copy afterwards
  assign browsing  = (state == BROWSE) || (state == BROWSE_REQ);
  assign addr_disp = 8'(show_err ? err_addr : rd_addr);
  assign data_disp = 8'(fresh ? rd_data : data_q);
  assign HEX5 = browsing ? seg(addr_disp[7:4]) : BLANK;
  assign HEX4 = browsing ? seg(addr_disp[3:0]) : BLANK;
  assign HEX3 = (browsing && err_flag) ? seg(4'hE) : BLANK;
  assign HEX2 = BLANK;
  assign HEX1 = browsing ? seg(data_disp[7:4]) : BLANK;
  assign HEX0 = browsing ? seg(data_disp[3:0]) : BLANK;
endmodule

// File: tb/tb_sorted_mem_reader.sv
// tb_sorted_mem_reader: directed bench with an 8-entry RAM model behind the read port
module tb_sorted_mem_reader;
  localparam logic [6:0] G [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [7:0] SORTED [8] = '{8'h01, 8'h03, 8'h03, 8'h07, 8'h10, 8'h2A, 8'h80, 8'hFF};
  logic tb_clk = 1'b0, rst_n = 1'b0, sort_done = 1'b0, step_n = 1'b1;
  logic [7:0] rd_addr, rd_data = 8'h00;
  logic rd_en, verify_done, sorted_ok, err_flag;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [7:0] mem [8];
  logic prev_en = 1'b0, dbl_rd = 1'b0;
  int rd_cnt = 0, checks = 0, fails = 0;
  always #5 tb_clk = ~tb_clk;
  sorted_mem_reader #(.ADDR_W(8), .DATA_W(8), .N(8)) dut (
    .clk(tb_clk), .rst_n(rst_n), .sort_done(sort_done), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .step_n(step_n), .verify_done(verify_done), .sorted_ok(sorted_ok),
    .err_flag(err_flag), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );
  always @(posedge tb_clk) begin
    if (rd_en) rd_data <= mem[rd_addr[2:0]];
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (rd_en && prev_en) dbl_rd <= 1'b1;
    prev_en <= rd_en;
  end
  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask
  task automatic load_sorted();
    for (int i = 0; i < 8; i++) mem[i] = SORTED[i];
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    sort_done = 1'b1;
    step_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!verify_done && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (!verify_done) begin
      fails++;
      $display("FAIL wait_done: verify_done never rose within %0d cycles", cyc);
    end
  endtask
  task automatic test_reset();
    load_sorted();
    rst_n = 1'b0;
    sort_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({rd_en, rd_addr, verify_done, sorted_ok, err_flag} !== 12'h0) begin
        fails++;
        $display("FAIL reset_outputs: got en=%b addr=%h vd=%b ok=%b err=%b, expected all 0",
                 rd_en, rd_addr, verify_done, sorted_ok, err_flag);
      end
      checks++;
      if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'h7F}}) begin
        fails++;
        $display("FAIL reset_hex: got %h expected all 7F", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({rd_en, rd_addr} !== {1'b1, 8'h00}) begin
      fails++;
      $display("FAIL first_read: got en=%b addr=%h expected en=1 addr=00", rd_en, rd_addr);
    end
  endtask
  task automatic test_sorted();
    int cyc, r0;
    load_sorted();
    do_reset();
    r0 = rd_cnt;
    wait_done(cyc);
    checks++;
    if (cyc !== 16) begin
      fails++;
      $display("FAIL scan_cycles: got %0d expected 16", cyc);
    end
    checks++;
    if ({sorted_ok, err_flag, rd_cnt - r0} !== {2'b10, 32'd8}) begin
      fails++;
      $display("FAIL sorted_flags: got ok=%b err=%b reads=%0d expected ok=1 err=0 reads=8",
               sorted_ok, err_flag, rd_cnt - r0);
    end
    repeat (3) tick();
    checks++;
    if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {G[0], G[0], 7'h7F, 7'h7F, G[0], G[1]}) begin
      fails++;
      $display("FAIL sorted_hex: got %h expected %h", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
               {G[0], G[0], 7'h7F, 7'h7F, G[0], G[1]});
    end
  endtask
  task automatic test_unsorted();
    int cyc, r0;
    load_sorted();
    mem[5] = 8'h02;
    do_reset();
    r0 = rd_cnt;
    wait_done(cyc);
    checks++;
    if ({sorted_ok, err_flag, rd_cnt - r0} !== {2'b01, 32'd8}) begin
      fails++;
      $display("FAIL unsorted_flags: got ok=%b err=%b reads=%0d expected ok=0 err=1 reads=8",
               sorted_ok, err_flag, rd_cnt - r0);
    end
    repeat (3) tick();
    checks++;
    if ({HEX5, HEX4, HEX3, HEX1, HEX0} !== {G[0], G[5], G[14], G[0], G[1]}) begin
      fails++;
      $display("FAIL unsorted_hex: got %h expected %h", {HEX5, HEX4, HEX3, HEX1, HEX0},
               {G[0], G[5], G[14], G[0], G[1]});
    end
  endtask
  task automatic test_browse_wrap();
    int cyc, r0, k;
    logic [7:0] v;
    load_sorted();
    do_reset();
    wait_done(cyc);
    repeat (3) tick();
    for (int p = 1; p <= 8; p++) begin
      k = p % 8;
      v = SORTED[k];
      r0 = rd_cnt;
      step_n = 1'b0;
      repeat (5) tick();
      step_n = 1'b1;
      repeat (3) tick();
      checks++;
      if ({rd_addr, rd_cnt - r0} !== {8'(k), 32'd1}) begin
        fails++;
        $display("FAIL browse_addr press %0d: got addr=%0d reads=%0d expected addr=%0d reads=1",
                 p, rd_addr, rd_cnt - r0, k);
      end
      checks++;
      if ({HEX5, HEX4, HEX1, HEX0} !== {G[0], G[k], G[v[7:4]], G[v[3:0]]}) begin
        fails++;
        $display("FAIL browse_hex press %0d: got %h expected %h", p, {HEX5, HEX4, HEX1, HEX0},
                 {G[0], G[k], G[v[7:4]], G[v[3:0]]});
      end
    end
  endtask
  task automatic test_held_button();
    int r0;
    r0 = rd_cnt;
    step_n = 1'b0;
    repeat (100) tick();
    step_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({rd_addr, rd_cnt - r0} !== {8'd1, 32'd1}) begin
      fails++;
      $display("FAIL held_button: got addr=%0d reads=%0d expected addr=1 reads=1", rd_addr, rd_cnt - r0);
    end
  endtask
  task automatic test_reset_mid_scan();
    int cyc, r0, n;
    load_sorted();
    do_reset();
    n = 0;
    while (!(rd_addr == 8'd3 && !rd_en) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (rd_addr !== 8'd3) begin
      fails++;
      $display("FAIL mid_scan_reach: got addr=%0d expected 3", rd_addr);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({rd_en, verify_done, sorted_ok, err_flag, HEX5} !== {4'b0000, 7'h7F}) begin
      fails++;
      $display("FAIL mid_scan_reset: got en=%b vd=%b ok=%b err=%b hex5=%h expected 0 0 0 0 7f",
               rd_en, verify_done, sorted_ok, err_flag, HEX5);
    end
    rst_n = 1'b1;
    tick();
    r0 = rd_cnt;
    checks++;
    if ({rd_en, rd_addr} !== {1'b1, 8'h00}) begin
      fails++;
      $display("FAIL restart_read: got en=%b addr=%h expected en=1 addr=00", rd_en, rd_addr);
    end
    for (int i = 0; i < 10; i++) begin
      step_n = ~step_n;
      sort_done = 1'b0;
      tick();
    end
    step_n = 1'b1;
    wait_done(cyc);
    checks++;
    if ({sorted_ok, rd_addr, rd_cnt - r0} !== {1'b1, 8'h00, 32'd8}) begin
      fails++;
      $display("FAIL scan_ignores_step: got ok=%b addr=%0d reads=%0d expected ok=1 addr=0 reads=8",
               sorted_ok, rd_addr, rd_cnt - r0);
    end
    repeat (3) tick();
    r0 = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      sort_done = ~sort_done;
      tick();
    end
    checks++;
    if ({verify_done, rd_addr, rd_cnt - r0} !== {1'b1, 8'h00, 32'd0}) begin
      fails++;
      $display("FAIL sort_done_retoggle: got vd=%b addr=%0d reads=%0d expected vd=1 addr=0 reads=0",
               verify_done, rd_addr, rd_cnt - r0);
    end
  endtask
  task automatic test_rd_en_spacing();
    checks++;
    if (dbl_rd !== 1'b0) begin
      fails++;
      $display("FAIL rd_en_spacing: got back-to-back rd_en=%b expected 0", dbl_rd);
    end
  endtask
  initial begin
    test_reset();
    test_sorted();
    test_unsorted();
    test_browse_wrap();
    test_held_button();
    test_reset_mid_scan();
    test_rd_en_spacing();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
